// File: rtl/bram_port_arbiter.sv
// Round-robin arbiter that shares one BRAM port between two requesters and
// steers read data back to the issuer through a latency-matched id pipe.
module bram_port_arbiter #(
  parameter int PIPELINED  = 0,
  parameter int ADDR_WIDTH = 1,
  parameter int DATA_WIDTH = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic                  req0_write,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  output logic                  rsp0_valid,
  output logic [DATA_WIDTH-1:0] rsp0_data,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic                  req1_write,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  output logic                  rsp1_valid,
  output logic [DATA_WIDTH-1:0] rsp1_data,
  output logic                  bram_en,
  output logic                  bram_we,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic [DATA_WIDTH-1:0] bram_di,
  input  logic [DATA_WIDTH-1:0] bram_do
);

  localparam int LAT = (PIPELINED != 0) ? 2 : 1;

  logic           last_gnt_r;
  logic           grant0_s;
  logic           grant1_s;
  logic           any_grant_s;
  logic           gnt_id_s;
  logic           rd_issue_s;
  logic [LAT-1:0] pipe_valid_r;
  logic [LAT-1:0] pipe_id_r;

  // Grant selection: a lone requester always wins, a conflict goes to !last_gnt_r.
  always_comb begin
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    if (!rst_n) begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end else if (req0_valid && req1_valid) begin
      grant0_s = last_gnt_r;
      grant1_s = !last_gnt_r;
    end else begin
      grant0_s = req0_valid;
      grant1_s = req1_valid;
    end
  end

  assign any_grant_s = grant0_s | grant1_s;
  assign gnt_id_s    = grant1_s;
  assign req0_ready  = grant0_s;
  assign req1_ready  = grant1_s;

  // BRAM port mux; idle cycles park addr/di on requester 0.
  always_comb begin
    bram_en    = any_grant_s;
    bram_we    = 1'b0;
    bram_addr  = req0_addr;
    bram_di    = req0_wdata;
    rd_issue_s = 1'b0;
    if (grant1_s) begin
      bram_we   = req1_write;
      bram_addr = req1_addr;
      bram_di   = req1_wdata;
    end else if (grant0_s) begin
      bram_we   = req0_write;
      bram_addr = req0_addr;
      bram_di   = req0_wdata;
    end else begin
      bram_we   = 1'b0;
    end
    rd_issue_s = any_grant_s && !bram_we;
  end

  // Round-robin history; reset value makes requester 0 win the first conflict.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt_r <= 1'b1;
    end else if (any_grant_s) begin
      last_gnt_r <= gnt_id_s;
    end else begin
      last_gnt_r <= last_gnt_r;
    end
  end

  // Read-tracking pipe, as deep as the BRAM read latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_valid_r <= {LAT{1'b0}};
      pipe_id_r    <= {LAT{1'b0}};
    end else begin
      pipe_valid_r[0] <= rd_issue_s;
      pipe_id_r[0]    <= gnt_id_s;
      for (int i = 1; i < LAT; i++) begin
        pipe_valid_r[i] <= pipe_valid_r[i-1];
        pipe_id_r[i]    <= pipe_id_r[i-1];
      end
    end
  end

  assign rsp0_valid = pipe_valid_r[LAT-1] && !pipe_id_r[LAT-1];
  assign rsp1_valid = pipe_valid_r[LAT-1] &&  pipe_id_r[LAT-1];
  assign rsp0_data  = bram_do;
  assign rsp1_data  = bram_do;

endmodule
